pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register, the generic successor of the fixed-field stage latches between IF/ID/EX/MEM/WB. It captures an opaque WIDTH-bit payload plus a valid bit from the upstream stage and presents it to the downstream stage. It obeys the central stall vector and flush line, inserts a bubble when only the upstream side is stalled, and carries a sticky sideband field that survives bubbles, as the delay-slot flag does. It also exports a saturating hold-cycle counter for stall diagnostics.

---
 rtl/pipe_stage_reg_pkg.sv | 35 +++
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants and the boundary-register action decode.
// Holds stall/reset polarity, per-stage NOP encodings and the per-edge action type.
package pipe_stage_reg_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  localparam logic [7:0] ALUOP_NOP     = 8'b0000_0000;
  localparam logic [2:0] ALUSEL_NOP    = 3'b000;
  localparam logic [4:0] NOP_REG_ADDR  = 5'b00000;
  localparam logic       WRITE_DISABLE = 1'b0;

  // id_ex payload: {aluop, alusel, reg1, reg2, wd, wreg}
  localparam int unsigned ID_EX_W = 8 + 3 + 32 + 32 + 5 + 1;
  localparam logic [ID_EX_W-1:0] ID_EX_NOP =
    {ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0, NOP_REG_ADDR, WRITE_DISABLE};

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } action_e;

  // su=0 with sd=1 cannot come from a prefix stall controller; it advances.
  function automatic action_e decode_action(input logic flush, input logic su,
                                            input logic sd);
    if (flush)                           return ACT_FLUSH;
    else if (su == STOP && sd != STOP)   return ACT_BUBBLE;
    else if (su != STOP)                 return ACT_ADVANCE;
    else                                 return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: payload + valid + sticky sideband,
// obeying the central stall vector and flush, with a saturating hold counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned            WIDTH     = 32,
  parameter int unsigned            KEEP_W    = 1,
  parameter int unsigned            STALL_W   = 6,
  parameter int unsigned            STAGE     = 2,
  parameter logic [WIDTH-1:0]       NOP_VALUE = '0,
  parameter int unsigned            CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [KEEP_W-1:0]  in_keep,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [KEEP_W-1:0]  out_keep,
  output logic [CNT_W-1:0]   hold_cnt
);

  // out_valid qualifies out_data; there is no ready signal. Downstream
  // back-pressure reaches this register only through stall[STAGE+1].

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               su;
  logic               sd;
  action_e            action;

  logic               valid_q,    valid_d;
  logic [WIDTH-1:0]   data_q,     data_d;
  logic [KEEP_W-1:0]  keep_q,     keep_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  assign su     = stall[STAGE];
  assign sd     = stall[STAGE+1];
  assign action = decode_action(flush, su, sd);

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    keep_d     = keep_q;
    hold_cnt_d = '0;
    case (action)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
        keep_d  = '0;
      end
      ACT_BUBBLE: begin
        // keep survives the bubble so a delay-slot flag is not lost
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
      end
      ACT_ADVANCE: begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : NOP_VALUE;
        keep_d  = in_keep;
      end
      ACT_HOLD: begin
        hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
      end
      default: begin
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_q    <= 1'b0;
      data_q     <= NOP_VALUE;
      keep_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed cases plus random traffic
// compared against a rule-level reference model.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned KEEP_W  = 1;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned STAGE   = 2;
  localparam logic [31:0] NOP     = 32'hDEAD_0000;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = 255;

  // clock / reset
  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic [KEEP_W-1:0]  in_keep;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [KEEP_W-1:0]  out_keep;
  logic [CNT_W-1:0]   hold_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(WIDTH), .KEEP_W(KEEP_W), .STALL_W(STALL_W), .STAGE(STAGE),
    .NOP_VALUE(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .hold_cnt(hold_cnt)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];
  int m_valid, m_keep, m_cnt;
  int illegal_seen = 0;
  int illegal_exp  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Illegal stall pattern flag: upstream running while downstream stalled.
  always @(posedge clk)
    if (!rst && stall[STAGE] == 1'b0 && stall[STAGE+1] == 1'b1) illegal_seen++;

  task automatic model_reset();
    m_valid = 0; m_keep = 0; m_cnt = 0;
    exp_q.delete();
    exp_q.push_back(NOP);
  endtask

  // Reference: one rule per action, highest priority first.
  task automatic model_edge();
    logic [WIDTH-1:0] md;
    int su, sd;
    md = exp_q.pop_front();
    su = stall[STAGE];
    sd = stall[STAGE+1];
    if (flush) begin
      m_valid = 0; md = NOP; m_keep = 0; m_cnt = 0;
    end else if (su == 1 && sd == 0) begin
      m_valid = 0; md = NOP; m_cnt = 0;
    end else if (su == 0) begin
      m_valid = in_valid; md = in_valid ? in_data : NOP; m_keep = in_keep; m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    exp_q.push_back(md);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_eq({tag, ".data"},  out_data,       exp_q[0]);
    check_eq({tag, ".keep"},  32'(out_keep),  32'(m_keep));
    check_eq({tag, ".cnt"},   32'(hold_cnt),  32'(m_cnt));
  endtask

  // driver tasks
  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [31:0] d, input logic k);
    stall = st; flush = fl; in_valid = v; in_data = d; in_keep = k;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(6'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // advance, then invalid advance exposes NOP
    drive(6'b000000, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    step("adv");
    check_eq("adv_data_const", out_data, 32'h1234_5678);
    drive(6'b000000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    step("adv_inv");
    check_eq("adv_inv_const", out_data, NOP);

    // bubble keeps the sticky sideband
    drive(6'b000000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    step("load");
    drive(6'b000111, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    step("bubble");
    check_eq("bubble_keep_const", 32'(out_keep), 32'd1);

    // hold and saturation
    drive(6'b000000, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    step("preload");
    drive(6'b001111, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
    for (int i = 0; i < 300; i++) step("hold");
    check_eq("hold_sat_const", 32'(hold_cnt), 32'd255);
    drive(6'b000000, 1'b0, 1'b1, 32'h7777_0000, 1'b0);
    step("post_hold");

    // flush beats stall with hold_cnt=5
    drive(6'b000000, 1'b0, 1'b1, 32'h1111_2222, 1'b1);
    step("pre_flush");
    drive(6'b001111, 1'b0, 1'b1, 32'h3333_4444, 1'b1);
    for (int i = 0; i < 5; i++) step("hold5");
    check_eq("hold5_const", 32'(hold_cnt), 32'd5);
    drive(6'b001111, 1'b1, 1'b1, 32'h3333_4444, 1'b1);
    step("flush");

    // illegal pattern advances
    drive(6'b001000, 1'b0, 1'b1, 32'h0F0F_F0F0, 1'b1);
    illegal_exp++;
    step("illegal");
    check_eq("illegal_data_const", out_data, 32'h0F0F_F0F0);

    // asynchronous reset mid-cycle during a hold
    drive(6'b001111, 1'b0, 1'b1, 32'h9999_9999, 1'b1);
    step("hold_pre_rst");
    step("hold_pre_rst");
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 rst = 1'b0;
    step("after_rst");

    // random traffic, mostly legal prefix stalls
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [5:0] st;
      k  = $urandom_range(0, 6);
      st = 6'((1 << k) - 1);
      if ($urandom_range(0, 49) == 0) begin
        st = 6'b001000;
        illegal_exp++;
      end
      drive(st, ($urandom_range(0, 15) == 0), 1'($urandom), $urandom, 1'($urandom));
      step("rand");
    end

    check_eq("illegal_count", 32'(illegal_seen), 32'(illegal_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
